// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the writeback arbiter and its result buffer.
//   REG_ADDR_W : width of a register-file address
//   DATA_W     : width of register-file data
//   NUM_REGS   : number of architectural registers (one busy bit each)
//   wb_entry_t : one buffered mul/div result (destination + data)
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of wb_entry_t holding long-latency mul/div results until the
// register-file write port is free.
// Optional feature macro: WB_SCOREBOARD_EN (exports per-slot valid flags and
// stored entries so the top can build its busy mask).
// Ports:
//   clk          : rising-edge clock
//   clr          : synchronous active-high clear (empties the FIFO)
//   push_i       : write push_entry_i at the tail (ignored when full)
//   push_entry_i : entry to store
//   pop_i        : discard the head entry (ignored when empty)
//   head_o       : entry at the head of the FIFO
//   count_o      : number of stored entries, 0..DEPTH
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
//   valid_o      : (WB_SCOREBOARD_EN) slot holds a live entry
//   entries_o    : (WB_SCOREBOARD_EN) raw storage array
// -----------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   push_i,
    input  wb_entry_t              push_entry_i,
    input  logic                   pop_i,
    output wb_entry_t              head_o,
    output logic [CNT_W-1:0]       count_o,
    output logic                   full_o,
    output logic                   empty_o
`ifdef WB_SCOREBOARD_EN
    ,
    output logic [DEPTH-1:0]       valid_o,
    output wb_entry_t [DEPTH-1:0]  entries_o
`endif
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    wb_entry_t [DEPTH-1:0] mem_q;

    logic pushOk;
    logic popOk;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rdPtr_q];

    // Requests that would overflow or underflow are dropped here so the
    // pointers can never drift apart from the count.
    assign pushOk = push_i && !full_o;
    assign popOk  = pop_i && !empty_o;

    // Pointer and occupancy next-state. DEPTH is a power of two, so letting
    // the pointers overflow their natural width gives the modulo-DEPTH wrap.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (clr) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (pushOk) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (popOk) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            if (pushOk && !popOk) begin
                count_d = count_q + 1'b1;
            end else if (popOk && !pushOk) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        wrPtr_q <= wrPtr_d;
        rdPtr_q <= rdPtr_d;
        count_q <= count_d;
    end

    // Storage needs no clear: liveness of a slot is defined purely by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (!clr && pushOk) begin
            mem_q[wrPtr_q] <= push_entry_i;
        end
    end

`ifdef WB_SCOREBOARD_EN
    // A slot is live when its distance from the read pointer (modulo DEPTH)
    // is smaller than the number of stored entries.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset  = '0;
        valid_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset     = PTR_W'(i) - rdPtr_q;
            valid_o[i] = ({1'b0, offset} < count_q);
        end
    end

    assign entries_o = mem_q;
`endif

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Arbitrates the single register-file write port between the in-order pipeline
// (absolute priority, never stalled) and a FIFO of mul/div results that drain
// whenever the pipeline leaves the port free. Outputs are registered.
// Optional feature macro: WB_SCOREBOARD_EN (adds busy_mask).
// Ports:
//   clk        : rising-edge clock
//   clr        : synchronous active-high clear
//   pipe_valid : pipeline writeback present this cycle
//   pipe_rd    : pipeline destination register
//   pipe_data  : pipeline writeback data
//   mdu_valid  : mul/div unit offers a result
//   mdu_rd     : mul/div destination register
//   mdu_data   : mul/div result data
//   mdu_ready  : result buffer can accept a mul/div result
//   wb_en      : register-file write enable
//   wb_number  : register-file write address
//   wb_data    : register-file write data
//   busy_mask  : (WB_SCOREBOARD_EN) registers with a buffered, unwritten result
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  pipe_valid,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0]     pipe_data,
    input  logic                  mdu_valid,
    input  logic [REG_ADDR_W-1:0] mdu_rd,
    input  logic [DATA_W-1:0]     mdu_data,
    output logic                  mdu_ready,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_number,
    output logic [DATA_W-1:0]     wb_data
`ifdef WB_SCOREBOARD_EN
    ,
    output logic [NUM_REGS-1:0]   busy_mask
`endif
);

    localparam int               CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic                  wbEn_q, wbEn_d;
    logic [REG_ADDR_W-1:0] wbNumber_q, wbNumber_d;
    logic [DATA_W-1:0]     wbData_q, wbData_d;

    logic             pipeWrite;
    logic             push;
    logic             pop;
    wb_entry_t        pushEntry;
    wb_entry_t        headEntry;
    logic [CNT_W-1:0] fifoCount;
    logic             fifoFull;
    logic             fifoEmpty;

`ifdef WB_SCOREBOARD_EN
    logic [DEPTH-1:0]      slotValid;
    wb_entry_t [DEPTH-1:0] slotEntries;
`endif

    // A pipeline writeback to x0 is dropped and leaves the port free. The
    // ready flag depends only on the registered count, so a pop in the same
    // cycle cannot make room for a push. Results for x0 are accepted but
    // never stored. The FIFO head is only considered when it was already
    // stored at the start of the cycle, so a fresh push is never bypassed.
    always_comb begin
        pipeWrite = pipe_valid && (pipe_rd != '0);
        mdu_ready = (fifoCount < FULL_COUNT) && !clr;
        push      = mdu_valid && mdu_ready && (mdu_rd != '0);
        pop       = !clr && !pipeWrite && !fifoEmpty;
        pushEntry = '{rd: mdu_rd, data: mdu_data};
    end

    wb_fifo #(
        .DEPTH        (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .clr          (clr),
        .push_i       (push),
        .push_entry_i (pushEntry),
        .pop_i        (pop),
        .head_o       (headEntry),
        .count_o      (fifoCount),
        .full_o       (fifoFull),
        .empty_o      (fifoEmpty)
`ifdef WB_SCOREBOARD_EN
        ,
        .valid_o      (slotValid),
        .entries_o    (slotEntries)
`endif
    );

    // Write-port selection: pipeline first, then FIFO head, else idle with
    // address and data held so the register file sees no spurious toggling.
    always_comb begin
        wbEn_d     = 1'b0;
        wbNumber_d = wbNumber_q;
        wbData_d   = wbData_q;
        if (clr) begin
            wbNumber_d = '0;
            wbData_d   = '0;
        end else if (pipeWrite) begin
            wbEn_d     = 1'b1;
            wbNumber_d = pipe_rd;
            wbData_d   = pipe_data;
        end else if (pop) begin
            wbEn_d     = 1'b1;
            wbNumber_d = headEntry.rd;
            wbData_d   = headEntry.data;
        end
    end

    always_ff @(posedge clk) begin
        wbEn_q     <= wbEn_d;
        wbNumber_q <= wbNumber_d;
        wbData_q   <= wbData_d;
    end

    // The FIFO reports full both as a flag and through its count; the two
    // views must never disagree outside of clear.
    always_ff @(posedge clk) begin
        if (!clr) begin
            assert (fifoFull == (fifoCount == FULL_COUNT));
        end
    end

    assign wb_en     = wbEn_q;
    assign wb_number = wbNumber_q;
    assign wb_data   = wbData_q;

`ifdef WB_SCOREBOARD_EN
    // Built from registered FIFO state, so a bit drops in the same cycle that
    // wb_en presents the popped entry. x0 is never reported busy.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slotValid[i]) begin
                busy_mask[slotEntries[i].rd] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end
`endif

endmodule
